// File: rtl/hamming_serial_rx.sv
// Serial Hamming receiver: codeword bits arrive LSB first, the last bit is corrected and loaded into a one-entry
// output buffer on its accept edge; only that last bit stalls (rx_ready=0) while the buffer is full and unpopped.
module hamming_serial_rx #(
   parameter int P = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_bit,
   input  logic                     rx_valid,
   input  logic                     rx_sof,
   output logic                     rx_ready,
   output logic [(2**P-P-1)-1:0]    out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_corrected,
   output logic [7:0]               corr_count,
   output logic [7:0]               resync_count
);

   localparam int N  = 2**P - 1;
   localparam int K  = 2**P - P - 1;
   localparam int CW = $clog2(N);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-2:0]  sr_q, sr_d;
   logic [K-1:0]  data_q, data_d;
   logic          valid_q, valid_d;
   logic          corr_q, corr_d;
   logic [7:0]    corr_cnt_q, corr_cnt_d;
   logic [7:0]    resync_cnt_q, resync_cnt_d;

   logic [N-1:0]  cw;
   logic [N-1:0]  fixed;
   logic [P-1:0]  syn;
   logic [K-1:0]  dec_data;
   logic          last;
   logic          accept;
   logic          pop;
   logic          resync;
   logic          load;

   assign last     = (cnt_q == CW'(N - 1));
   assign rx_ready = !(last && valid_q && !out_ready);
   assign accept   = rx_valid && rx_ready;
   assign pop      = valid_q && out_ready;
   assign resync   = accept && rx_sof && (cnt_q != '0);
   assign load     = accept && last && !resync;

   // Syndrome bit j covers every Hamming position whose index has bit j set.
   always_comb begin
      cw  = {rx_bit, sr_q};
      syn = '0;
      for (int j = 0; j < P; j++) begin
         for (int i = 0; i < N; i++) begin
            if ((((i + 1) >> j) & 1) == 1) begin
               syn[j] = syn[j] ^ cw[i];
            end
         end
      end
      fixed = cw;
      for (int i = 0; i < N; i++) begin
         if (syn == P'(i + 1)) begin
            fixed[i] = ~cw[i];
         end
      end
      // Data bits sit at non-power-of-two positions; shift them in so the lowest lands at bit 0.
      dec_data = '0;
      for (int i = 0; i < N; i++) begin
         if (((i + 1) & i) != 0) begin
            dec_data = K'({fixed[i], dec_data} >> 1);
         end
      end
   end

   always_comb begin
      cnt_d        = cnt_q;
      sr_d         = sr_q;
      data_d       = data_q;
      valid_d      = valid_q;
      corr_d       = corr_q;
      corr_cnt_d   = corr_cnt_q;
      resync_cnt_d = resync_cnt_q;

      if (accept) begin
         sr_d = {rx_bit, sr_q[N-2:1]};
         if (resync) begin
            cnt_d = CW'(1);
         end else if (last) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (load) begin
         data_d  = dec_data;
         valid_d = 1'b1;
         corr_d  = (syn != '0);
         if ((syn != '0) && (corr_cnt_q != 8'hFF)) begin
            corr_cnt_d = corr_cnt_q + 8'd1;
         end
      end else if (pop) begin
         valid_d = 1'b0;
      end

      if (resync && (resync_cnt_q != 8'hFF)) begin
         resync_cnt_d = resync_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         sr_q         <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         corr_q       <= 1'b0;
         corr_cnt_q   <= '0;
         resync_cnt_q <= '0;
      end else begin
         cnt_q        <= cnt_d;
         sr_q         <= sr_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         corr_q       <= corr_d;
         corr_cnt_q   <= corr_cnt_d;
         resync_cnt_q <= resync_cnt_d;
      end
   end

   assign out_data      = data_q;
   assign out_valid     = valid_q;
   assign out_corrected = corr_q;
   assign corr_count    = corr_cnt_q;
   assign resync_count  = resync_cnt_q;

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Randomized bench for hamming_serial_rx: a frame-level reference model feeds a scoreboard queue that an
// independent output monitor pops whenever a word leaves the DUT.
module tb_hamming_serial_rx;

   logic       clk;
   logic       rst;
   logic       rx_bit;
   logic       rx_valid;
   logic       rx_sof;
   logic       rx_ready;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_corrected;
   logic [7:0] corr_count;
   logic [7:0] resync_count;

   int         total = 0;
   int         bad = 0;
   logic [4:0] exp_q[$];
   logic       bitbuf[$];
   int         m_corr = 0;
   int         m_resync = 0;
   int         rdy_mode = 1;
   logic       ovr_vld = 1'b0;
   logic [4:0] ovr_val = '0;
   int         stall_cycles = 0;
   int         pops = 0;

   hamming_serial_rx #(.P(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_bit        (rx_bit),
      .rx_valid      (rx_valid),
      .rx_sof        (rx_sof),
      .rx_ready      (rx_ready),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_corrected (out_corrected),
      .corr_count    (corr_count),
      .resync_count  (resync_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Syndrome = XOR of the 1-based positions of all set bits; returns {corrected, data}.
   function automatic logic [4:0] ref_decode(input logic [6:0] word);
      int         s;
      logic [6:0] c;
      s = 0;
      c = word;
      for (int i = 0; i < 7; i++) begin
         if (c[i]) s = s ^ (i + 1);
      end
      if (s != 0) c = c ^ (7'd1 << (s - 1));
      return {(s != 0), c[6], c[5], c[4], c[2]};
   endfunction

   task automatic model_accept(input logic b, input logic sof);
      logic [6:0] word;
      logic [4:0] r;
      if (sof && bitbuf.size() != 0) begin
         bitbuf.delete();
         if (m_resync < 255) m_resync++;
      end
      bitbuf.push_back(b);
      if (bitbuf.size() == 7) begin
         for (int i = 0; i < 7; i++) word[i] = bitbuf[i];
         r = ref_decode(word);
         if (r[4] && m_corr < 255) m_corr++;
         exp_q.push_back(ovr_vld ? ovr_val : r);
         bitbuf.delete();
      end
   endtask

   task automatic send_bit(input logic b, input logic sof);
      int waited;
      waited = 0;
      @(negedge clk);
      rx_bit   = b;
      rx_sof   = sof;
      rx_valid = 1'b1;
      forever begin
         #4;
         if (rx_ready) break;
         waited++;
         stall_cycles++;
         if (waited > 200) begin
            total++;
            bad++;
            $display("FAIL rx_stall_timeout: rx_ready stuck at 0 for %0d cycles, required 1", waited);
            rx_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      model_accept(b, sof);
      #1;
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
   endtask

   task automatic send_frame(input logic [6:0] word, input logic sof0);
      for (int i = 0; i < 7; i++) send_bit(word[i], (i == 0) ? sof0 : 1'b0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      rdy_mode = 1;
      while ((exp_q.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      #3;
      total++;
      if (exp_q.size() != 0 || out_valid) begin
         bad++;
         $display("FAIL drain: %0d words pending, out_valid=%b, required 0 pending", exp_q.size(), out_valid);
      end
   endtask

   // Output monitor: picks out_ready each cycle and scores every word popped on the following edge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rdy_mode == 0) out_ready = 1'($urandom_range(0, 1));
         else out_ready = (rdy_mode == 1);
         if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got %h, required no word", {out_corrected, out_data});
            end else begin
               check("word", {27'd0, out_corrected, out_data}, {27'd0, exp_q.pop_front()});
            end
         end
      end
   end

   initial begin
      logic [6:0] word;
      logic [6:0] frame_b;
      logic       sof;
      int         n;
      int         st0;
      int         p0;

      rst      = 1'b1;
      rx_bit   = 1'b0;
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_corrected", out_corrected, 0);
      check("rst_corr_count", corr_count, 0);
      check("rst_resync_count", resync_count, 0);
      check("rst_rx_ready", rx_ready, 1);
      rst = 1'b0;

      // Clean frame, then a data-bit error and a parity-bit error.
      ovr_vld = 1'b1;
      ovr_val = {1'b0, 4'b1011};
      send_frame(7'b1010101, 1'b1);
      check("latency_out_valid", out_valid, 1);
      drain();
      check("clean_corr_count", corr_count, 0);
      ovr_val = {1'b1, 4'b1011};
      send_frame(7'b1000101, 1'b1);
      drain();
      check("data_err_corr_count", corr_count, 1);
      ovr_val = {1'b1, 4'b0000};
      send_frame(7'b0000001, 1'b0);
      drain();
      check("parity_err_corr_count", corr_count, 2);

      // Backpressure: second frame's last bit must stall until the first word is popped.
      rdy_mode = 2;
      @(negedge clk);
      ovr_val = {1'b0, 4'b1011};
      send_frame(7'b1010101, 1'b0);
      frame_b = 7'b0110011;
      ovr_val = {1'b0, 4'b0110};
      for (int i = 0; i < 6; i++) send_bit(frame_b[i], 1'b0);
      st0 = stall_cycles;
      fork
         send_bit(frame_b[6], 1'b0);
         begin
            repeat (3) @(negedge clk);
            #3;
            check("bp_rx_ready", rx_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 4'b1011);
            rdy_mode = 1;
         end
      join
      check("bp_no_bubble", out_valid, 1);
      check("bp_stalled", (stall_cycles > st0), 1);
      drain();

      // Resync: three stray bits, then a fresh frame flagged with rx_sof.
      ovr_val = {1'b0, 4'b1011};
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), (i == 0));
      send_frame(7'b1010101, 1'b1);
      drain();
      check("resync_count", resync_count, 1);

      // Reset in the middle of a frame discards the partial bits and both counters.
      for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      bitbuf.delete();
      m_corr   = 0;
      m_resync = 0;
      check("midrst_corr_count", corr_count, 0);
      check("midrst_resync_count", resync_count, 0);
      check("midrst_out_valid", out_valid, 0);
      rst = 1'b0;
      p0 = pops;
      send_frame(7'b1010101, 1'b0);
      drain();
      check("midrst_word_count", pops - p0, 1);
      ovr_vld = 1'b0;

      // Random frames with random gaps, stray prefixes and random consumer backpressure.
      rdy_mode = 0;
      for (int f = 0; f < 500; f++) begin
         word = 7'($urandom);
         sof  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), (i == 0));
            sof = 1'b1;
         end
         for (int i = 0; i < 7; i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send_bit(word[i], (i == 0) ? sof : 1'b0);
         end
      end
      drain();
      check("rand_corr_count", corr_count, m_corr);
      check("rand_resync_count", resync_count, m_resync);
      check("corr_count_saturated", corr_count, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hamming_serial_rx.md
HAMMING_SERIAL_RX -- requirements
Module: hamming_serial_rx

Interface
REQ-001 SHALL have parameter P, default 3, Hamming parity-bit count; codeword width N = 2**P-1 and data width K = 2**P-P-1. Only P=3 (N=7, K=4) is required.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx_bit  input  1  serial codeword bit.
REQ-005 SHALL have port rx_valid  input  1  rx_bit is valid this cycle.
REQ-006 SHALL have port rx_sof  input  1  qualified by rx_valid; marks the accepted bit as codeword bit 0.
REQ-007 SHALL have port rx_ready  output  1  block accepts rx_bit this cycle.
REQ-008 SHALL have port out_data  output  K  corrected data word.
REQ-009 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-011 SHALL have port out_corrected  output  1  held word had a nonzero syndrome and one bit was flipped.
REQ-012 SHALL have port corr_count  output  8  saturating count of corrected frames.
REQ-013 SHALL have port resync_count  output  8  saturating count of partial frames discarded by rx_sof.

Function
REQ-014 SHALL accept a bit only in a cycle with rx_valid=1 and rx_ready=1; bits arrive LSB first, codeword bit 0 first.
REQ-015 SHALL use codeword layout [6:0] = {d3,d2,d1,p4,d0,p2,p1}, i.e. bit i is Hamming position i+1.
REQ-016 SHALL compute syndrome s = {s4,s2,s1}, where s1 = XOR of positions 1,3,5,7; s2 = XOR of positions 2,3,6,7; s4 = XOR of positions 4,5,6,7.
REQ-017 SHALL invert codeword bit s-1 when s!=0, leave the codeword unchanged when s=0, then extract out_data = {d3,d2,d1,d0}.
REQ-018 SHALL keep a bit counter 0..6 and a 6-bit shift register; the counter increments per accepted bit and wraps 6->0.
REQ-019 SHALL decode combinationally from the shift register plus the incoming bit on acceptance of bit 6, and load out_data, out_corrected and out_valid=1 on the next edge; latency from the bit-6 accept edge to out_valid=1 is 1 cycle.
REQ-020 SHALL form a one-entry output buffer: out_valid clears on the edge where out_valid=1 and out_ready=1, unless a new word loads on the same edge.
REQ-021 SHALL drive rx_ready=0 only when counter=6, out_valid=1 and out_ready=0; the final bit stalls and no frame is ever dropped.
REQ-022 SHALL, on same-cycle final-bit accept and output pop, load the new word and hold out_valid=1 with no bubble.
REQ-023 SHALL, when an accepted bit has rx_sof=1 and counter!=0, discard the partial frame, store the bit as bit 0, set counter=1, and increment resync_count.
REQ-024 SHALL ignore rx_sof=1 at counter=0, with no resync count.
REQ-025 SHALL increment corr_count when a word with s!=0 loads; both counters saturate at 255.
REQ-026 SHALL hold all outputs and state stable while rx_valid=0 and no pop occurs.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, clear the counter, shift register, out_data, out_valid, out_corrected, corr_count and resync_count to 0.
REQ-028 SHALL give rst priority over all other inputs; a partial frame in flight during reset is discarded.
REQ-029 SHALL accept the first bit on the edge after rst deasserts (rx_ready=1 while out_valid=0).

Verification
REQ-030 SHALL pass clean frame: serial 7'b1010101 with out_ready=1 -> out_data=4'b1011, out_corrected=0, corr_count=0, out_valid one cycle after bit 6.
REQ-031 SHALL pass single-bit error: 7'b1000101 (bit 4 flipped) -> s=5, out_data=4'b1011, out_corrected=1, corr_count=1.
REQ-032 SHALL pass parity-bit error: 7'b0000001 -> s=1, out_data=4'b0000, out_corrected=1.
REQ-033 SHALL pass backpressure: out_ready=0 with two frames sent back to back -> rx_ready=0 at the second frame's bit 6 until the first pop; both words delivered in order.
REQ-034 SHALL pass resync: 3 bits, then an rx_sof bit, then 6 more bits of 7'b1010101 -> resync_count=1, out_data=4'b1011.
REQ-035 SHALL pass reset mid-frame: rst asserted after 4 bits, then a full frame 7'b1010101 -> exactly one word, 4'b1011.
